// File: rtl/cordic_tx_pkg.sv
// Shared state encoding and default widths for the TX keyer.
// No logic; no latency; no flow control.
package cordic_tx_pkg;

    localparam int DEF_IN_WIDTH = 16;
    localparam int DEF_WF       = 32;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN,
        ST_GUARD,
        ST_RETUNE
    } keyer_state_t;

endpackage

// File: rtl/cordic_tx_keyer_if.sv
// Keyer control/data bundle: PTT, frequency handshake, baseband in/out, status.
// No latency of its own; freq_valid/freq_ready carry the only backpressure.
interface cordic_tx_keyer_if #(
    parameter int IN_WIDTH = 16,
    parameter int WF       = 32
);
    logic                       ptt;
    logic signed [WF-1:0]       freq_in;
    logic                       freq_valid;
    logic                       freq_ready;
    logic signed [IN_WIDTH-1:0] in_data_I;
    logic signed [IN_WIDTH-1:0] in_data_Q;
    logic signed [IN_WIDTH-1:0] out_data_I;
    logic signed [IN_WIDTH-1:0] out_data_Q;
    logic signed [WF-1:0]       frequency;
    logic                       tx_active;
    logic                       ramp_busy;

    modport master (
        output ptt, freq_in, freq_valid, in_data_I, in_data_Q,
        input  freq_ready, out_data_I, out_data_Q, frequency, tx_active, ramp_busy
    );

    modport slave (
        input  ptt, freq_in, freq_valid, in_data_I, in_data_Q,
        output freq_ready, out_data_I, out_data_Q, frequency, tx_active, ramp_busy
    );
endinterface

// File: rtl/cordic_tx_gain_mul.sv
// One baseband channel scaled by the ramp gain: out = floor(in * gain / 2^RAMP_BITS).
// Latency 1 cycle; no backpressure, samples every clock.
module cordic_tx_gain_mul #(
    parameter int IN_WIDTH  = 16,
    parameter int RAMP_BITS = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic signed [IN_WIDTH-1:0] in_data,
    input  logic        [RAMP_BITS:0]  gain,
    output logic signed [IN_WIDTH-1:0] out_data
);
    // |in * gain| <= 2^(IN_WIDTH-1+RAMP_BITS), so this width never overflows
    localparam int PW = IN_WIDTH + RAMP_BITS + 1;

    logic signed [PW-1:0] in_ext;
    logic signed [PW-1:0] gain_ext;

    assign in_ext   = {{(PW-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    assign gain_ext = {{(PW-RAMP_BITS-1){1'b0}}, gain};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            out_data <= '0;
        end else begin
            out_data <= IN_WIDTH'((in_ext * gain_ext) >>> RAMP_BITS);
        end
    end
endmodule

// File: rtl/cordic_tx_keyer.sv
// Keying/retune sequencer: owns the NCO word, ramps I/Q gain so keying and retunes never step.
// Baseband latency 1 cycle; freq_ready is low outside OFF/ON. CORDIC_TX_KEYER_GUARD_EN adds a zero-gain GUARD before retune.
module cordic_tx_keyer
    import cordic_tx_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int WF        = DEF_WF,
    parameter int RAMP_BITS = 8
`ifdef CORDIC_TX_KEYER_GUARD_EN
    ,
    parameter int GUARD_CYCLES = 20
`endif
) (
    input  logic               clock,
    input  logic               reset_n,
    cordic_tx_keyer_if.slave   bus
);
    localparam logic [RAMP_BITS:0] GAIN_FULL = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [RAMP_BITS:0] GAIN_TOP  = GAIN_FULL - 1'b1;

`ifdef CORDIC_TX_KEYER_GUARD_EN
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam keyer_state_t AFTER_DOWN = ST_GUARD;
    logic [GW-1:0] guard_cnt_q, guard_cnt_d;
`else
    localparam keyer_state_t AFTER_DOWN = ST_RETUNE;
`endif

    keyer_state_t         state_q, state_d;
    logic [RAMP_BITS:0]   gain_q, gain_d;
    logic signed [WF-1:0] freq_q, freq_d;
    logic signed [WF-1:0] pend_freq_q, pend_freq_d;
    logic                 retune_pend_q, retune_pend_d;
    logic                 freq_rdy;
    logic                 xfer;

    assign freq_rdy = (state_q == ST_OFF) || (state_q == ST_ON);
    assign xfer     = bus.freq_valid && freq_rdy;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= ST_OFF;
            gain_q        <= '0;
            freq_q        <= '0;
            pend_freq_q   <= '0;
            retune_pend_q <= 1'b0;
`ifdef CORDIC_TX_KEYER_GUARD_EN
            guard_cnt_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            gain_q        <= gain_d;
            freq_q        <= freq_d;
            pend_freq_q   <= pend_freq_d;
            retune_pend_q <= retune_pend_d;
`ifdef CORDIC_TX_KEYER_GUARD_EN
            guard_cnt_q   <= guard_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        gain_d        = gain_q;
        freq_d        = freq_q;
        pend_freq_d   = pend_freq_q;
        retune_pend_d = retune_pend_q;
`ifdef CORDIC_TX_KEYER_GUARD_EN
        guard_cnt_d   = guard_cnt_q;
`endif
        case (state_q)
            ST_OFF: begin
                gain_d = '0;
                if (xfer) freq_d = bus.freq_in;
                if (bus.ptt) state_d = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                // Dropping PTT reverses from the current gain, so no step
                if (!bus.ptt) begin
                    state_d = ST_RAMP_DOWN;
                end else begin
                    gain_d = gain_q + 1'b1;
                    if (gain_q == GAIN_TOP) state_d = ST_ON;
                end
            end
            ST_ON: begin
                gain_d = GAIN_FULL;
                if (xfer) begin
                    pend_freq_d   = bus.freq_in;
                    retune_pend_d = 1'b1;
                    state_d       = ST_RAMP_DOWN;
                end else if (!bus.ptt) begin
                    state_d = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (gain_q != '0) gain_d = gain_q - 1'b1;
                if (gain_q[RAMP_BITS:1] == '0)
                    state_d = retune_pend_q ? AFTER_DOWN : ST_OFF;
            end
`ifdef CORDIC_TX_KEYER_GUARD_EN
            ST_GUARD: begin
                if (guard_cnt_q == GW'(GUARD_CYCLES - 1)) begin
                    guard_cnt_d = '0;
                    state_d     = ST_RETUNE;
                end else begin
                    guard_cnt_d = guard_cnt_q + 1'b1;
                end
            end
`endif
            ST_RETUNE: begin
                freq_d        = pend_freq_q;
                retune_pend_d = 1'b0;
                state_d       = bus.ptt ? ST_RAMP_UP : ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
                gain_d  = '0;
            end
        endcase
    end

    assign bus.freq_ready = freq_rdy;
    assign bus.frequency  = freq_q;
    assign bus.tx_active  = (state_q != ST_OFF);
    assign bus.ramp_busy  = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN) ||
                            (state_q == ST_RETUNE)  || (state_q == ST_GUARD);

    cordic_tx_gain_mul #(.IN_WIDTH(IN_WIDTH), .RAMP_BITS(RAMP_BITS)) u_mul_i (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_data  (bus.in_data_I),
        .gain     (gain_q),
        .out_data (bus.out_data_I)
    );

    cordic_tx_gain_mul #(.IN_WIDTH(IN_WIDTH), .RAMP_BITS(RAMP_BITS)) u_mul_q (
        .clock    (clock),
        .reset_n  (reset_n),
        .in_data  (bus.in_data_Q),
        .gain     (gain_q),
        .out_data (bus.out_data_Q)
    );
endmodule
